// File: rtl/cp0_if.sv
// rtl/cp0_if.sv - M-stage exception, mtc0/mfc0 and trap signals between pipeline and cp0
// The pipeline side is the master; cp0 is the slave.
interface cp0_if;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [5:0]  hwint;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret;
  logic [31:0] cp0_rdata;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  modport master (
    output exc_valid, exc_code, exc_pc, exc_bd, hwint,
    output cp0_we, cp0_addr, cp0_wdata, eret,
    input  cp0_rdata, req, handler_pc, epc_out
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_bd, hwint,
    input  cp0_we, cp0_addr, cp0_wdata, eret,
    output cp0_rdata, req, handler_pc, epc_out
  );
endinterface

// File: rtl/cp0.sv
// rtl/cp0.sv - coprocessor 0: SR/Cause/EPC/PRId, trap decision and eret target
// Traps are decided combinationally from the registered M-stage inputs.
module cp0 #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h1823_1051
) (
  input  logic  clk,
  input  logic  reset,
  cp0_if.slave  bus
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        trap;
  logic [31:0] trap_epc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  always_comb begin
    int_req = (|(bus.hwint & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_req = bus.exc_valid & ~sr_exl_q;
    trap    = (int_req | exc_req) & ~reset;
  end

  assign bus.req        = trap;
  assign bus.handler_pc = HANDLER_PC;

  always_comb begin
    sr_word    = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
    cause_word = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};
  end

  always_comb begin
    bus.cp0_rdata = 32'b0;
    case (bus.cp0_addr)
      5'd12:   bus.cp0_rdata = sr_word;
      5'd13:   bus.cp0_rdata = cause_word;
      5'd14:   bus.cp0_rdata = epc_q;
      5'd15:   bus.cp0_rdata = PRID;
      default: bus.cp0_rdata = 32'b0;
    endcase
  end

  // An mtc0 EPC in the same cycle as eret must steer the return address.
  always_comb begin
    if (bus.cp0_we && bus.cp0_addr == 5'd14)
      bus.epc_out = bus.cp0_wdata & 32'hFFFF_FFFC;
    else
      bus.epc_out = epc_q;
  end

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = bus.hwint;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    trap_epc    = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;

    if (trap) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_req ? 5'd0 : bus.exc_code;
      cause_bd_d  = bus.exc_bd;
      epc_d       = trap_epc & 32'hFFFF_FFFC;
    end else if (bus.eret) begin
      sr_exl_d = 1'b0;
    end else if (bus.cp0_we) begin
      case (bus.cp0_addr)
        5'd12: begin
          sr_im_d  = bus.cp0_wdata[15:10];
          sr_exl_d = bus.cp0_wdata[1];
          sr_ie_d  = bus.cp0_wdata[0];
        end
        5'd14:   epc_d = bus.cp0_wdata & 32'hFFFF_FFFC;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q     <= 6'b0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'b0;
      cause_exc_q <= 5'b0;
      epc_q       <= 32'b0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

endmodule
